serial_transmitter: RTL and testbench

// - Serialises bytes from the microprocessor PIO onto a single line for the serial receiver at the far end.
// - Frame: idle high, 1 start bit (0), DATA_WIDTH data bits MSB first, 1 stop bit (1).
// - Sits between the microprocessor (data_bus_out / load / transmit_enable / character_sent) and a GPIO pin.
// - A one-deep holding register lets software load the next byte while the current one is shifting.
//

---
 rtl/serial_transmitter_if.sv | 22 ++
 rtl/serial_transmitter.sv | 149 ++++++++++++++
 tb/tb_serial_transmitter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serial_transmitter_if.sv
// Processor-side bus of the serial transmitter: byte/strobe/enable in, line and status out.
interface serial_transmitter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  load;
  logic                  transmit_enable;
  logic                  data_out;
  logic                  ready;
  logic                  busy;
  logic                  character_sent;

  modport master (
    output data_in, load, transmit_enable,
    input  data_out, ready, busy, character_sent
  );

  modport slave (
    input  data_in, load, transmit_enable,
    output data_out, ready, busy, character_sent
  );
endinterface

// File: rtl/serial_transmitter.sv
// Byte serialiser: start bit, DATA_WIDTH bits MSB first, stop bit, with a one-deep holding register.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_transmitter_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cycle_reg, cycle_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] hold_reg, hold_next;
  logic                  parity_reg, parity_next;
  logic                  ready_reg, ready_next;
  logic                  line_reg, line_next;
  logic                  busy_reg, busy_next;
  logic                  sent_reg, sent_next;
  logic                  bit_done;
  logic                  start_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cycle_reg  <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      hold_reg   <= '0;
      parity_reg <= 1'b0;
      ready_reg  <= 1'b1;
      line_reg   <= 1'b1;
      busy_reg   <= 1'b0;
      sent_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cycle_reg  <= cycle_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      hold_reg   <= hold_next;
      parity_reg <= parity_next;
      ready_reg  <= ready_next;
      line_reg   <= line_next;
      busy_reg   <= busy_next;
      sent_reg   <= sent_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    hold_next   = hold_reg;
    parity_next = parity_reg;
    ready_next  = ready_reg;
    sent_next   = 1'b0;
    bit_done    = (cycle_reg == LAST_CYC);
    // ready_reg low means the holding register carries a byte waiting to go out
    start_ok    = !ready_reg && bus.transmit_enable;
    cycle_next  = (state_reg == IDLE || bit_done) ? '0 : cycle_reg + 1'b1;

    if (bus.load && ready_reg) begin
      hold_next  = bus.data_in;
      ready_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          shift_next  = hold_reg;
          parity_next = ^hold_reg;
          ready_next  = 1'b1;
          state_next  = START;
        end
      end
      START: begin
        bit_next = '0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_next = shift_reg << 1;
          if (bit_reg == LAST_BIT) begin
            bit_next = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          sent_next = 1'b1;
          // chaining straight into START keeps back-to-back frames gap-free
          if (start_ok) begin
            shift_next  = hold_reg;
            parity_next = ^hold_reg;
            ready_next  = 1'b1;
            state_next  = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // line value is derived from the next state so the output stays registered
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shift_next[DATA_WIDTH-1];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  line_next = parity_next;
`endif
      default: line_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign bus.data_out       = line_reg;
  assign bus.ready          = ready_reg;
  assign bus.busy           = busy_reg;
  assign bus.character_sent = sent_reg;
endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter at CLKS_PER_BIT=4, DATA_WIDTH=8; inputs and samples on the falling edge.
module tb_serial_transmitter;
  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_transmitter_if #(.DATA_WIDTH(DW)) bus();

  serial_transmitter #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // expected line level for frame bit j of byte b
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= DW) return b[DW-j];
`ifdef SERIAL_TX_PARITY_EN
    if (j == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic start_idle(input logic [7:0] b);
    bus.load = 1'b1;
    bus.data_in = b;
    tick();
    chk("load_ready_low", 32'(bus.ready), 32'd0);
    chk("load_line_idle", 32'(bus.data_out), 32'd1);
    bus.load = 1'b0;
    tick();
    chk("start_ready_back", 32'(bus.ready), 32'd1);
  endtask

  // Called on the first start-bit sample; ends on the sample after the last stop cycle.
  task automatic check_frame(input logic [7:0] b, input bit nxt_v, input logic [7:0] nxt,
                             input bit junk_v, input logic [7:0] junk, input bit chained);
    for (int i = 0; i < NB * CPB; i++) begin
      chk($sformatf("line_%02h_c%0d", b, i), 32'(bus.data_out), 32'(exp_bit(b, i / CPB)));
      chk("busy_in_frame", 32'(bus.busy), 32'd1);
      if (i > 0) chk("no_early_sent", 32'(bus.character_sent), 32'd0);
      if (i == 0 && nxt_v) begin
        bus.load = 1'b1;
        bus.data_in = nxt;
      end else if (i == 1 && nxt_v) begin
        chk("queued_ready_low", 32'(bus.ready), 32'd0);
        bus.load = junk_v;
        bus.data_in = junk_v ? junk : ~nxt;
      end else begin
        bus.load = 1'b0;
        bus.data_in = 8'hFF;
      end
      tick();
    end
    chk("char_sent_pulse", 32'(bus.character_sent), 32'd1);
    chk("busy_after_frame", 32'(bus.busy), chained ? 32'd1 : 32'd0);
    chk("line_after_frame", 32'(bus.data_out), chained ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load = 1'b0;
    bus.data_in = '0;
    bus.transmit_enable = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_line", 32'(bus.data_out), 32'd1);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sent", 32'(bus.character_sent), 32'd0);
    rst = 1'b0;
    bus.transmit_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_line", 32'(bus.data_out), 32'd1);
    end

    // single byte
    start_idle(8'hA5);
    check_frame(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    chk("sent_one_cycle", 32'(bus.character_sent), 32'd0);

    // back-to-back, no idle gap
    start_idle(8'h3C);
    check_frame(8'h3C, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b1);
    check_frame(8'hC3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();

    // overrun: third load while ready=0 is dropped
    start_idle(8'h11);
    check_frame(8'h11, 1'b1, 8'h22, 1'b1, 8'h33, 1'b1);
    check_frame(8'h22, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("overrun_idle_line", 32'(bus.data_out), 32'd1);
      chk("overrun_ready", 32'(bus.ready), 32'd1);
    end

    // enable gating
    bus.transmit_enable = 1'b0;
    bus.load = 1'b1;
    bus.data_in = 8'hF0;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("gated_line", 32'(bus.data_out), 32'd1);
      chk("gated_busy", 32'(bus.busy), 32'd0);
      chk("gated_ready", 32'(bus.ready), 32'd0);
      tick();
    end
    bus.transmit_enable = 1'b1;
    tick();
    check_frame(8'hF0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();

    // reset mid-frame, 13 cycles in
    start_idle(8'h5A);
    for (int i = 0; i < 12; i++) tick();
    chk("midframe_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_line", 32'(bus.data_out), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_sent", 32'(bus.character_sent), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_abort_sent", 32'(bus.character_sent), 32'd0);
      chk("post_abort_line", 32'(bus.data_out), 32'd1);
    end
    start_idle(8'h81);
    check_frame(8'h81, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();

    // low-weight byte (parity bit 1 when parity is built in)
    start_idle(8'h07);
    check_frame(8'h07, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
